// File: rtl/param_updown_counter.sv
// Up/down modulo counter with clock prescaler, saturating parallel load and registered wrap pulse.
// Define PUC_HEX_DISPLAY_EN to add the active-low seven-segment output hex_out.
module param_updown_counter #(
   parameter int WIDTH   = 8,
   parameter int MAX_VAL = 255,
   parameter int DIV     = 1
) (
   input  logic             clk,
   input  logic             clear_b,
   input  logic             enable,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             tc
`ifdef PUC_HEX_DISPLAY_EN
   ,
   output logic [7*((WIDTH+3)/4)-1:0] hex_out
`endif
);

   localparam int               PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
   localparam logic [PW-1:0]    DIV_LAST = PW'(DIV - 1);

   logic [PW-1:0]    presc_reg, presc_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic             tc_reg, tc_next;

   // With DIV=1 the prescaler never leaves 0, so tick degenerates to enable.
   assign tick = enable & clear_b & (presc_reg == DIV_LAST);

   always_comb begin
      count_next = count_reg;
      presc_next = presc_reg;
      tc_next    = 1'b0;
      if (load) begin
         count_next = (load_val > MAX_W) ? MAX_W : load_val;
         presc_next = '0;
      end else if (tick) begin
         presc_next = '0;
         if (up) begin
            if (count_reg == MAX_W) begin
               count_next = '0;
               tc_next    = 1'b1;
            end else begin
               count_next = count_reg + WIDTH'(1);
            end
         end else begin
            if (count_reg == '0) begin
               count_next = MAX_W;
               tc_next    = 1'b1;
            end else begin
               count_next = count_reg - WIDTH'(1);
            end
         end
      end else if (enable) begin
         presc_next = presc_reg + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge clear_b) begin
      if (!clear_b) begin
         count_reg <= '0;
         presc_reg <= '0;
         tc_reg    <= 1'b0;
      end else begin
         count_reg <= count_next;
         presc_reg <= presc_next;
         tc_reg    <= tc_next;
      end
   end

   assign count = count_reg;
   assign tc    = tc_reg;

`ifdef PUC_HEX_DISPLAY_EN
   localparam int ND   = (WIDTH + 3) / 4;
   localparam int PADW = 4 * ND;

   logic [PADW-1:0] count_pad;
   assign count_pad = PADW'(count_reg);

   // Segment bit 0 = a ... bit 6 = g, low = lit.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0:    seg7 = 7'b1000000;
         4'h1:    seg7 = 7'b1111001;
         4'h2:    seg7 = 7'b0100100;
         4'h3:    seg7 = 7'b0110000;
         4'h4:    seg7 = 7'b0011001;
         4'h5:    seg7 = 7'b0010010;
         4'h6:    seg7 = 7'b0000010;
         4'h7:    seg7 = 7'b1111000;
         4'h8:    seg7 = 7'b0000000;
         4'h9:    seg7 = 7'b0010000;
         4'hA:    seg7 = 7'b0001000;
         4'hB:    seg7 = 7'b0000011;
         4'hC:    seg7 = 7'b1000110;
         4'hD:    seg7 = 7'b0100001;
         4'hE:    seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < ND; gi++) begin : g_digit
         assign hex_out[7*gi +: 7] = seg7(count_pad[4*gi +: 4]);
      end
   endgenerate
`endif

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the lab 8-bit enabled T-flip-flop counter. Generalised width and programmable wrap value (modulus). Adds up/down direction, synchronous parallel load, a built-in clock prescaler and a registered terminal-count pulse. Sits between board switches/keys and the seven-segment display path; also usable as a timebase for later labs.

Parameters:
WIDTH, 8, counter width in bits; legal range 1 to 32.
MAX_VAL, 255, highest count value before wrap; must satisfy MAX_VAL < 2**WIDTH.
DIV, 1, prescale ratio: count steps once per DIV enabled clocks; must satisfy DIV >= 1.

Ports:
clk  input  1  rising-edge clock
clear_b  input  1  asynchronous active-low reset; clears all state
enable  input  1  active-high count enable; gates the prescaler
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value captured on load
count  output  WIDTH  current count, registered
tick  output  1  combinational step strobe: the count advances on this clock edge
tc  output  1  registered terminal-count pulse, one clock wide

Behaviour:
- Reset (clear_b=0, asynchronous, any time including mid-count): count=0, prescaler=0, tc=0. tick reads 0 while clear_b=0. State holds at these values until clear_b returns to 1; the first step then occurs on the first rising edge with tick=1.
- Prescaler: internal register of width clog2(DIV), minimum 1 bit.
  - enable=1: prescaler increments each clock.
  - tick = enable AND (prescaler == DIV-1). On a tick, the prescaler returns to 0.
  - enable=0: prescaler holds its value; tick=0.
  - DIV=1: tick = enable (the prescaler is unused), so the counter steps every enabled clock.
- Priority per clock edge: load > tick step > hold.
- Load (load=1, regardless of enable):
  - count <= min(load_val, MAX_VAL), saturating.
  - prescaler <= 0; tc <= 0.
  - A tick asserted in the same cycle is discarded.
- Step (tick=1, load=0):
  - up=1: count <= (count == MAX_VAL) ? 0 : count+1.
  - up=0: count <= (count == 0) ? MAX_VAL : count-1.
  - Comparisons use WIDTH-bit arithmetic. There is no out-of-range state, because load saturates.
- tc: registered. It is 1 in the cycle immediately after a wrapping step (MAX_VAL->0 when up, 0->MAX_VAL when down), and 0 in every other cycle.
- Direction change: up is sampled only on the tick edge. Toggling up between ticks has no effect on the prescaler or on count until the next tick.
- Hold (no load, no tick): count and the prescaler are unchanged except as described for enable=1 above; tc=0.
- Latency:
  - count reflects a load or step 1 clock after the edge.
  - tc aligns with the count value produced by the wrap.
- No combinational path from inputs to count or tc; tick is the only combinational output.

Optional Feature:
Macro PUC_HEX_DISPLAY_EN.
- Defined: adds output port hex_out, width 7*ceil(WIDTH/4). Each 7-bit group drives one digit, least-significant nibble in the lowest group.
  - Segments are active-low, segment order 0..6 = a..g, glyphs 0-9 and A-F, matching the existing lab display decoder.
  - Purely combinational from count.
  - A partial top nibble is zero-extended.
- Not defined: port hex_out is absent; no decoder logic is generated.
- Counter behaviour is identical in both builds.

Test Plan:
1. WIDTH=8, MAX_VAL=255, DIV=1. Release clear_b, enable=1, up=1, run 256 clocks -> count 0,1,...,255,0; tc=1 only in the cycle where count reads 0 after 255.
2. WIDTH=4, MAX_VAL=9, DIV=3, up=1, enable=1 -> tick every 3rd clock; count 0..9, then 0; tc one-cycle pulse coincident with count returning to 0 at tick 10 (clock 30).
3. MAX_VAL=9, up=0, count=0, one tick -> count=9, tc=1 next cycle. Then load=1 with load_val=14 -> count=9 (saturated), tc=0.
4. DIV=4: enable=1 for 2 clocks, enable=0 for 5 clocks, enable=1 -> the first tick occurs on the 2nd re-enabled clock (prescaler held at 2); count steps exactly once.
5. load=1 and tick=1 in the same cycle with load_val=5 -> count=5, prescaler=0, no step applied. Pulse clear_b low between clock edges mid-count -> count=0 immediately, before the next clock edge.
6. With PUC_HEX_DISPLAY_EN, WIDTH=8: load 8'h3C -> hex_out[13:7]=7'b0110000 ("3"), hex_out[6:0]=7'b1000110 ("C").
